// File: rtl/iagc_cmd_framer_pkg.sv
// Shared definitions for the IAGC command path: framer states, sync marker
// and the operation codes understood by the control FSM.
package iagc_cmd_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    WAIT_CMD  = 2'd1,
    WAIT_CHK  = 2'd2,
    PENDING   = 2'd3
  } framer_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    CMD_EMPTY     = 4'd0,
    CMD_START     = 4'd1,
    CMD_STOP      = 4'd2,
    CMD_SET_GAIN  = 4'd3,
    CMD_SET_REF   = 4'd4,
    CMD_RESET_ACC = 4'd5,
    CMD_STATUS    = 4'd6,
    CMD_DUMP      = 4'd7,
    CMD_HALT      = 4'd8
  } cmd_op_e;

endpackage

// File: rtl/iagc_cmd_framer_if.sv
// Byte-in / command-out bundle between UART RX, framer and control FSM.
// master = framer side, slave = the UART RX / control FSM side.
interface iagc_cmd_framer_if #(
  parameter int DATA_SIZE      = 8,
  parameter int CMD_PARAM_SIZE = 4
);
  logic [DATA_SIZE-1:0]      i_rx_data;
  logic                      i_rx_valid;
  logic                      i_cmd_ready;
  logic                      o_cmd_valid;
  logic [CMD_PARAM_SIZE-1:0] o_cmd_operation;
  logic [CMD_PARAM_SIZE-1:0] o_cmd_parameter;
  logic                      o_frame_error;
  logic                      o_overrun;
  logic [7:0]                o_error_count;

  modport master (
    input  i_rx_data, i_rx_valid, i_cmd_ready,
    output o_cmd_valid, o_cmd_operation, o_cmd_parameter,
    output o_frame_error, o_overrun, o_error_count
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_cmd_ready,
    input  o_cmd_valid, o_cmd_operation, o_cmd_parameter,
    input  o_frame_error, o_overrun, o_error_count
  );
endinterface

// File: rtl/iagc_cmd_framer_timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles and flags the one where the
// count has reached TIMEOUT_CYCLES-1; clear restarts from zero.
module iagc_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_SIZE   = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [TIMEOUT_SIZE-1:0] LAST = TIMEOUT_SIZE'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_SIZE-1:0] count_q, count_d;

  assign o_expired = i_enable && !i_clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (i_clear || o_expired) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/iagc_cmd_framer.sv
// Frames sync/command/checksum bytes from the UART into held commands.
// Optional saturating error counter enabled by IAGC_CMD_FRAMER_ERR_CNT_EN.
module iagc_cmd_framer
  import iagc_cmd_pkg::*;
#(
  parameter int                   DATA_SIZE      = 8,
  parameter int                   CMD_PARAM_SIZE = 4,
  parameter logic [DATA_SIZE-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int                   TIMEOUT_CYCLES = 1000000,
  parameter int                   TIMEOUT_SIZE   = 20
) (
  input  logic               i_clock,
  input  logic               i_reset,
  iagc_cmd_framer_if.master  bus
);
  framer_state_e             state_q;
  logic [DATA_SIZE-1:0]      cmd_byte_q;
  logic [CMD_PARAM_SIZE-1:0] operation_q;
  logic [CMD_PARAM_SIZE-1:0] parameter_q;
  logic                      cmd_valid_q;
  logic                      frame_error_q;
  logic                      overrun_q;

  logic in_frame;
  logic tmo_clear;
  logic tmo_expired;
  logic checksum_ok;
  logic frame_error_d;
  logic overrun_d;

  assign in_frame    = (state_q == WAIT_CMD) || (state_q == WAIT_CHK);
  assign tmo_clear   = bus.i_rx_valid || !in_frame;
  assign checksum_ok = (bus.i_rx_data == (SYNC_BYTE ^ cmd_byte_q));

  iagc_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_SIZE   (TIMEOUT_SIZE)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (tmo_clear),
    .i_enable  (in_frame),
    .o_expired (tmo_expired)
  );

  // Expiry is already masked by an arriving byte, so the byte always wins.
  always_comb begin
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    if (state_q == WAIT_CHK && bus.i_rx_valid && !checksum_ok) begin
      frame_error_d = 1'b1;
    end
    if (tmo_expired) begin
      frame_error_d = 1'b1;
    end
    if (state_q == PENDING && bus.i_rx_valid) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= WAIT_SYNC;
      cmd_byte_q    <= '0;
      operation_q   <= CMD_PARAM_SIZE'(CMD_EMPTY);
      parameter_q   <= '0;
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      case (state_q)
        WAIT_SYNC: begin
          if (bus.i_rx_valid && bus.i_rx_data == SYNC_BYTE) begin
            state_q <= WAIT_CMD;
          end
        end
        WAIT_CMD: begin
          if (bus.i_rx_valid) begin
            cmd_byte_q <= bus.i_rx_data;
            state_q    <= WAIT_CHK;
          end else if (tmo_expired) begin
            state_q <= WAIT_SYNC;
          end
        end
        WAIT_CHK: begin
          if (bus.i_rx_valid) begin
            if (checksum_ok) begin
              operation_q <= cmd_byte_q[DATA_SIZE-1 -: CMD_PARAM_SIZE];
              parameter_q <= cmd_byte_q[CMD_PARAM_SIZE-1:0];
              cmd_valid_q <= 1'b1;
              state_q     <= PENDING;
            end else begin
              state_q <= WAIT_SYNC;
            end
          end else if (tmo_expired) begin
            state_q <= WAIT_SYNC;
          end
        end
        PENDING: begin
          // Fields stay put after the handshake; the FSM samples them later.
          if (bus.i_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= WAIT_SYNC;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign bus.o_cmd_valid     = cmd_valid_q;
  assign bus.o_cmd_operation = operation_q;
  assign bus.o_cmd_parameter = parameter_q;
  assign bus.o_frame_error   = frame_error_q;
  assign bus.o_overrun       = overrun_q;

`ifdef IAGC_CMD_FRAMER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      err_cnt_q <= 8'h00;
    end else if ((frame_error_d || overrun_d) && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign bus.o_error_count = err_cnt_q;
`else
  assign bus.o_error_count = 8'h00;
`endif

endmodule

// File: tb/tb_iagc_cmd_framer.sv
// Self-checking bench for iagc_cmd_framer: directed frames from the test plan
// followed by randomized frames, compared every cycle against a frame model.
module tb_iagc_cmd_framer;
  import iagc_cmd_pkg::*;

  localparam int T = 16;
`ifdef IAGC_CMD_FRAMER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  iagc_cmd_framer_if bus ();

  iagc_cmd_framer #(
    .TIMEOUT_CYCLES (T),
    .TIMEOUT_SIZE   (5)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: collected frame bytes, idle-cycle count, pending command.
  logic [7:0] m_buf[$];
  int         m_idle = 0;
  bit         m_pend = 1'b0;
  logic [3:0] m_op   = 4'h0;
  logic [3:0] m_par  = 4'h0;
  int         m_cnt  = 0;
  bit         e_ferr = 1'b0;
  bit         e_ovr  = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".valid"}, 8'(bus.o_cmd_valid), 8'(m_pend));
    check({ctx, ".op"},    8'(bus.o_cmd_operation), 8'(m_op));
    check({ctx, ".param"}, 8'(bus.o_cmd_parameter), 8'(m_par));
    check({ctx, ".ferr"},  8'(bus.o_frame_error), 8'(e_ferr));
    check({ctx, ".ovr"},   8'(bus.o_overrun), 8'(e_ovr));
    check({ctx, ".cnt"},   bus.o_error_count, CNT_EN ? 8'(m_cnt) : 8'h00);
  endtask

  function automatic void model_step(input bit rxv, input logic [7:0] d, input bit rdy);
    logic [7:0] c;
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    if (m_pend) begin
      if (rxv) e_ovr = 1'b1;
      if (rdy) m_pend = 1'b0;
    end else if (rxv) begin
      m_idle = 0;
      if (m_buf.size() == 0) begin
        if (d == 8'hA5) m_buf.push_back(d);
      end else if (m_buf.size() == 1) begin
        m_buf.push_back(d);
      end else begin
        c = m_buf[1];
        if (d == (m_buf[0] ^ c)) begin
          m_op   = c[7:4];
          m_par  = c[3:0];
          m_pend = 1'b1;
        end else begin
          e_ferr = 1'b1;
        end
        m_buf.delete();
      end
    end else if (m_buf.size() != 0) begin
      if (m_idle == T - 1) begin
        e_ferr = 1'b1;
        m_buf.delete();
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if ((e_ferr || e_ovr) && CNT_EN && m_cnt < 255) m_cnt++;
  endfunction

  task automatic cycle(input bit rxv, input logic [7:0] d, input bit rdy, input string ctx);
    bus.i_rx_valid  = rxv;
    bus.i_rx_data   = d;
    bus.i_cmd_ready = rdy;
    model_step(rxv, d, rdy);
    @(posedge clk);
    #1;
    check_all(ctx);
    $display("cyc rxv=%0b data=%h rdy=%0b -> valid=%0b op=%h par=%h ferr=%0b ovr=%0b cnt=%0d [%s]",
             rxv, d, rdy, bus.o_cmd_valid, bus.o_cmd_operation, bus.o_cmd_parameter,
             bus.o_frame_error, bus.o_overrun, bus.o_error_count, ctx);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input bit rdy, input string ctx);
    cycle(1'b1, a, rdy, ctx);
    cycle(1'b1, b, rdy, ctx);
    cycle(1'b1, c, rdy, ctx);
  endtask

  task automatic idle(input int n, input bit rdy, input string ctx);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, ctx);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    m_buf.delete();
    m_idle = 0;
    m_pend = 1'b0;
    m_op   = 4'h0;
    m_par  = 4'h0;
    m_cnt  = 0;
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    bus.i_rx_valid = 1'b0;
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] cb, bytes[3];
    int kind, gap;
    bus.i_rx_valid  = 1'b0;
    bus.i_rx_data   = 8'h00;
    bus.i_cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    frame(8'hA5, 8'h23, 8'h86, 1'b1, "good_frame");
    idle(3, 1'b1, "good_hold");
    frame(8'hA5, 8'h23, 8'h87, 1'b1, "bad_chk");
    idle(2, 1'b1, "bad_chk_idle");

    frame(8'hA5, 8'h34, 8'h91, 1'b0, "backpressure");
    idle(20, 1'b0, "bp_wait");
    cycle(1'b1, 8'hA5, 1'b0, "overrun");
    idle(3, 1'b0, "bp_wait2");
    cycle(1'b0, 8'h00, 1'b1, "handshake");
    idle(2, 1'b1, "post_hs");

    cycle(1'b1, 8'hA5, 1'b1, "tmo_sync");
    idle(T + 1, 1'b1, "tmo_idle");
    frame(8'hA5, 8'h10, 8'hB5, 1'b1, "after_tmo");
    idle(2, 1'b1, "after_tmo_idle");

    cycle(1'b1, 8'h00, 1'b1, "garbage");
    cycle(1'b1, 8'hFF, 1'b1, "garbage");
    frame(8'hA5, 8'h70, 8'hD5, 1'b1, "garbage_frame");
    idle(2, 1'b1, "garbage_idle");
    cycle(1'b1, 8'hA5, 1'b1, "partial");
    cycle(1'b1, 8'h42, 1'b1, "partial");
    mid_reset();
    idle(T + 2, 1'b1, "post_reset");

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 4);
      if (kind <= 1) begin
        cb = 8'($urandom);
        bytes[0] = 8'hA5;
        bytes[1] = cb;
        bytes[2] = (8'hA5 ^ cb) ^ ((kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00);
        for (int b = 0; b < 3; b++) begin
          gap = ($urandom_range(0, 9) == 0) ? (T - 1 + $urandom_range(0, 2))
                                            : $urandom_range(0, 2);
          for (int g = 0; g < gap; g++)
            cycle(1'b0, 8'($urandom), 1'($urandom), "rnd_gap");
          cycle(1'b1, bytes[b], 1'($urandom), "rnd_frame");
        end
      end else if (kind == 2) begin
        cycle(1'b1, 8'($urandom), 1'($urandom), "rnd_byte");
      end else begin
        idle($urandom_range(1, 5), 1'($urandom), "rnd_idle");
      end
    end
    idle(T + 2, 1'b1, "rnd_drain");

    for (int n = 0; n < 300; n++) frame(8'hA5, 8'h00, 8'h00, 1'b1, "sat_frame");
    idle(2, 1'b1, "sat_idle");
    check("sat_final", bus.o_error_count, CNT_EN ? 8'hFF : 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iagc_cmd_framer.md
Name: iagc_cmd_framer

Overview:
- Converts the byte stream from the UART receiver into validated commands for the IAGC control FSM.
- Frame format: sync byte, then a command byte (operation in the upper nibble, parameter in the lower nibble), then a checksum byte.
- Presents operation/parameter with a valid/ready handshake and holds them stable until the next good frame.
- Sits between the UART RX and the control FSM's command inputs.

Parameters:
- DATA_SIZE, 8, UART byte width.
- CMD_PARAM_SIZE, 4, operation and parameter field width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes within one frame.
- TIMEOUT_SIZE, 20, timeout counter width; must satisfy 2^TIMEOUT_SIZE >= TIMEOUT_CYCLES.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  DATA_SIZE  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle
- i_cmd_ready  in  1  control FSM can accept a command (high while the FSM is idle)
- o_cmd_valid  out  1  validated command pending
- o_cmd_operation  out  CMD_PARAM_SIZE  operation field, held after handshake
- o_cmd_parameter  out  CMD_PARAM_SIZE  parameter field, held after handshake
- o_frame_error  out  1  one-cycle pulse on checksum error or timeout
- o_overrun  out  1  one-cycle pulse when a byte is dropped while a command is pending
- o_error_count  out  8  saturating error count (see Optional Feature)

Behaviour:
- Reset (i_reset low, asynchronous):
  - State returns to WAIT_SYNC.
  - All outputs go to 0; operation and parameter go to 4'b0000 (CMD_EMPTY).
  - The timeout counter clears.
  - Asserting reset mid-frame discards the partial frame with no error pulse.
- States:
  - WAIT_SYNC:
    - i_rx_valid with i_rx_data == SYNC_BYTE -> WAIT_CMD.
    - Any other byte is silently ignored.
  - WAIT_CMD:
    - On i_rx_valid, capture the byte into cmd_byte -> WAIT_CHK.
    - A SYNC_BYTE value received here is a legal command byte; no resynchronisation.
  - WAIT_CHK:
    - On i_rx_valid, compare i_rx_data against SYNC_BYTE ^ cmd_byte.
    - Match: load o_cmd_operation = cmd_byte[7:4] and o_cmd_parameter = cmd_byte[3:0] -> PENDING. o_cmd_valid goes high the following cycle.
    - Mismatch: pulse o_frame_error -> WAIT_SYNC. Operation and parameter registers are unchanged.
  - PENDING:
    - o_cmd_valid = 1.
    - When o_cmd_valid && i_cmd_ready in the same cycle: handshake completes -> WAIT_SYNC; o_cmd_valid drops the next cycle.
    - Any i_rx_valid while in PENDING: byte dropped, o_overrun pulses. This includes the cycle of the handshake.
- Timeout:
  - The counter runs only in WAIT_CMD and WAIT_CHK.
  - It clears on every accepted byte and on entry to either state.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte: pulse o_frame_error -> WAIT_SYNC.
  - If a byte arrives in the same cycle the timeout fires, the byte wins and no error is raised.
- Latency: o_cmd_valid is high 1 cycle after the checksum byte's i_rx_valid.
- Operation and parameter never change while o_cmd_valid is high. They stay stable after the handshake, because the FSM samples them two cycles later.
- Outputs are registered; o_frame_error and o_overrun are single-cycle pulses.

Optional Feature:
- Macro: IAGC_CMD_FRAMER_ERR_CNT_EN.
- Defined: o_error_count is an 8-bit counter.
  - It increments on every o_frame_error or o_overrun pulse.
  - It saturates at 8'hFF.
  - It clears only on reset.
  - If both pulses occur in the same cycle, it increments by 1.
- Undefined: o_error_count is tied to 8'h00 and no counter logic is synthesised.

Decomposition:
- Package iagc_cmd_pkg contains:
  - framer state encodings (WAIT_SYNC=2'd0, WAIT_CMD=2'd1, WAIT_CHK=2'd2, PENDING=2'd3);
  - the SYNC_BYTE default;
  - the CMD_* operation codes shared with the control FSM (EMPTY=0 through HALT=8).
- Sub-module iagc_timeout_counter:
  - Ports: clear, enable, and an expired output.
  - Parameterised by TIMEOUT_CYCLES and TIMEOUT_SIZE.
  - Reused later by the dump path.

Test Plan:
- Valid frame: A5, 23, 86 with i_cmd_ready=1 -> o_cmd_valid high for exactly 1 cycle, op=4'h2, param=4'h3, values held afterwards.
- Bad checksum: A5, 23, 87 -> one o_frame_error pulse, o_cmd_valid stays 0, op/param keep their previous values.
- Backpressure and overrun:
  - Frame A5, 34, 91 sent with i_cmd_ready=0 for 20 cycles -> o_cmd_valid stays high and stable.
  - A byte sent during the wait -> one o_overrun pulse.
  - Raise i_cmd_ready -> handshake completes, return to WAIT_SYNC.
- Timeout with TIMEOUT_CYCLES=16: A5 then 16 idle cycles -> o_frame_error pulse. A following A5, 10, B5 -> op=1, param=0 accepted.
- Garbage before sync: 00, FF, A5, 70, D5 -> op=7, param=0. Asserting i_reset mid-frame -> all outputs 0 with no error pulse.
- With IAGC_CMD_FRAMER_ERR_CNT_EN: 300 bad frames -> o_error_count saturates at 8'hFF. Without the macro: o_error_count stays 0.
